exc_sequencer: RTL and testbench

//  Exception/interrupt entry-exit controller that sequences CP0 and the pipeline.

---
 rtl/exc_sequencer_pkg.sv | 26 ++
 rtl/exc_sequencer_irq_sync.sv | 24 ++
 rtl/exc_sequencer.sv | 112 +++++++++++
 tb/tb_exc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/exc_sequencer_pkg.sv
// Shared CP0 definitions for the exception sequencer: ExcCodes, cause field
// positions, PC redirect encodings and FSM states.
package exc_sequencer_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int CAUSE_BD  = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [1:0] PC_SEQ     = 2'b00;
  localparam logic [1:0] PC_HANDLER = 2'b01;
  localparam logic [1:0] PC_EPC     = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/exc_sequencer_irq_sync.sv
// 6-bit two-flop synchronizer for asynchronous external interrupt lines.
module irq_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d,
  output logic [5:0] q
);

  logic [5:0] sync_p0;
  logic [5:0] sync_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry-exit sequencer: cause assembly, flush and PC redirect.
// Define IRQ_SYNC_EN to pass hwint through a 2-flop synchronizer before use.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hwint,
  input  logic        m_valid,
  input  logic [4:0]  exc_m,
  input  logic        bd_m,
  input  logic        eret_m,
  input  logic        intreq,
  input  logic [31:0] epc_i,
  output logic [31:0] cause_o,
  output logic        flush,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_target,
  output logic        exlclr,
  output logic        busy
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    initial $error("exc_sequencer: FLUSH_CYCLES=%0d outside 1..15", FLUSH_CYCLES);
  end

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [5:0] ip_s;

`ifdef IRQ_SYNC_EN
  irq_sync u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (hwint),
    .q   (ip_s)
  );
`else
  assign ip_s = hwint;
`endif

  state_t     state;
  logic [3:0] cnt;
  logic       take;

  assign take = (state == ST_IDLE) && (intreq || (eret_m && m_valid));

  // HOLD only exists to stretch flush beyond the entry cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take && (FLUSH_CYCLES > 1)) begin
            state <= ST_HOLD;
            cnt   <= CNT_LOAD;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Redirect is combinational so the handler fetch lands on the next edge;
  // reset masks everything so an asserted rst drops flush at once.
  always_comb begin
    cause_o   = '0;
    flush     = 1'b0;
    pc_sel    = PC_SEQ;
    pc_target = HANDLER_ADDR;
    exlclr    = 1'b0;
    busy      = 1'b0;
    if (rst) begin
      if (state == ST_HOLD) begin
        flush = 1'b1;
        busy  = 1'b1;
      end else begin
        if (m_valid) begin
          cause_o[CAUSE_BD]                  = bd_m;
          cause_o[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_s;
          cause_o[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_m;
        end
        if (intreq) begin
          flush  = 1'b1;
          pc_sel = PC_HANDLER;
        end else if (eret_m && m_valid) begin
          flush     = 1'b1;
          pc_sel    = PC_EPC;
          pc_target = epc_i;
          exlclr    = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: three instances (FLUSH_CYCLES 1, 3, 5) against a
// cycle-count reference model, directed steps followed by random traffic.
module tb_exc_sequencer;
  import exc_sequencer_pkg::*;

  localparam logic [31:0] HADDR = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hwint;
  logic        m_valid;
  logic [4:0]  exc_m;
  logic        bd_m;
  logic        eret_m;
  logic        intreq;
  logic [31:0] epc_i;

  logic [31:0] c1, c3, c5, t1, t3, t5;
  logic [1:0]  s1, s3, s5;
  logic        f1, f3, f5, x1, x3, x5, b1, b3, b5;
  logic [68:0] obs [3];

  always #5 clk = ~clk;

  exc_sequencer #(.HANDLER_ADDR(HADDR), .FLUSH_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .hwint(hwint), .m_valid(m_valid), .exc_m(exc_m),
    .bd_m(bd_m), .eret_m(eret_m), .intreq(intreq), .epc_i(epc_i),
    .cause_o(c1), .flush(f1), .pc_sel(s1), .pc_target(t1), .exlclr(x1), .busy(b1));
  exc_sequencer #(.HANDLER_ADDR(HADDR), .FLUSH_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .hwint(hwint), .m_valid(m_valid), .exc_m(exc_m),
    .bd_m(bd_m), .eret_m(eret_m), .intreq(intreq), .epc_i(epc_i),
    .cause_o(c3), .flush(f3), .pc_sel(s3), .pc_target(t3), .exlclr(x3), .busy(b3));
  exc_sequencer #(.HANDLER_ADDR(HADDR), .FLUSH_CYCLES(5)) u5 (
    .clk(clk), .rst(rst), .hwint(hwint), .m_valid(m_valid), .exc_m(exc_m),
    .bd_m(bd_m), .eret_m(eret_m), .intreq(intreq), .epc_i(epc_i),
    .cause_o(c5), .flush(f5), .pc_sel(s5), .pc_target(t5), .exlclr(x5), .busy(b5));

  assign obs[0] = {c1, f1, s1, t1, x1, b1};
  assign obs[1] = {c3, f3, s3, t3, x3, b3};
  assign obs[2] = {c5, f5, s5, t5, x5, b5};

  // Reference model: each taken event flushes cycles [k, k+FC); hold_end is the
  // first cycle index that is no longer flushed.
  int         fcs [3] = '{1, 3, 5};
  int         cyc = 0;
  int         hold_end [3] = '{0, 0, 0};
  logic [5:0] h1 = '0, h2 = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1 <= '0;
      h2 <= '0;
      for (int i = 0; i < 3; i++) hold_end[i] <= 0;
    end else begin
      cyc <= cyc + 1;
      h1  <= hwint;
      h2  <= h1;
      for (int i = 0; i < 3; i++)
        if (!(cyc < hold_end[i]) && (intreq || (eret_m && m_valid)))
          hold_end[i] <= cyc + fcs[i];
    end
  end

  function automatic logic [68:0] exp_vec(int i);
    logic [31:0] c;
    logic [5:0]  ip;
    logic        inhold;
`ifdef IRQ_SYNC_EN
    ip = h2;
`else
    ip = hwint;
`endif
    inhold = (cyc < hold_end[i]);
    if (!rst) return {32'h0, 1'b0, 2'b00, HADDR, 1'b0, 1'b0};
    if (inhold) return {32'h0, 1'b1, 2'b00, HADDR, 1'b0, 1'b1};
    c = m_valid ? {bd_m, 15'b0, ip, 3'b0, exc_m, 2'b0} : 32'h0;
    if (intreq) return {c, 1'b1, 2'b01, HADDR, 1'b0, 1'b0};
    if (eret_m && m_valid) return {c, 1'b1, 2'b10, epc_i, 1'b1, 1'b0};
    return {c, 1'b0, 2'b00, HADDR, 1'b0, 1'b0};
  endfunction

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [68:0] o, input logic [68:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s/fc%0d", tag, fcs[i]), obs[i], exp_vec(i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; hwint = 6'h3F; intreq = 1'b1; m_valid = 1'b1;
    exc_m = '0; bd_m = 1'b0; eret_m = 1'b0; epc_i = '0;

    // Reset with everything asserted
    at_neg();
    check("reset_u1", obs[0], {32'h0, 1'b0, 2'b00, 32'h4180, 1'b0, 1'b0});
    check("reset_u5", obs[2], {32'h0, 1'b0, 2'b00, 32'h4180, 1'b0, 1'b0});
    check_all("reset");

    // Interrupt cause, then entry
    step();
    rst = 1'b1; intreq = 1'b0; hwint = 6'b000100; exc_m = EXC_INT;
    step(); step();
    at_neg();
    check("irq_cause", {37'h0, c1}, {37'h0, 32'h0000_1000});
    check_all("irq_cause");
    step(); intreq = 1'b1;
    at_neg();
    check("irq_entry", obs[0], {32'h0000_1000, 1'b1, 2'b01, 32'h4180, 1'b0, 1'b0});
    check_all("irq_entry");
    step(); intreq = 1'b0;
    for (int k = 0; k < 6; k++) begin at_neg(); check_all("irq_drain"); step(); end

    // Bubble deferral
    m_valid = 1'b0; hwint = 6'h01;
    step(); step(); step();
    at_neg();
    check("bubble", {37'h0, c1}, 69'h0);
    check_all("bubble");
    step(); m_valid = 1'b1;
    at_neg();
    check("bubble_own", {37'h0, c1}, {37'h0, 32'h0000_0400});

    // ERET
    step(); eret_m = 1'b1; epc_i = 32'h0000_3010;
    at_neg();
    check("eret", obs[0], {32'h0000_0400, 1'b1, 2'b10, 32'h3010, 1'b1, 1'b0});
    check_all("eret");
    step(); eret_m = 1'b0;
    at_neg();
    check("eret_end", {67'h0, f1, x1}, 69'h0);
    check_all("eret_end");
    for (int k = 0; k < 6; k++) begin step(); at_neg(); check_all("eret_drain"); end

    // Collision and HOLD (FLUSH_CYCLES=3)
    step(); hwint = 6'h00; bd_m = 1'b1; exc_m = EXC_OV;
    step(); step(); step();
    at_neg();
    check("coll_cause", {37'h0, c3}, {37'h0, 32'h8000_0030});
    step(); intreq = 1'b1; eret_m = 1'b1;
    at_neg();
    check("coll_entry", obs[1], {32'h8000_0030, 1'b1, 2'b01, 32'h4180, 1'b0, 1'b0});
    check_all("coll_entry");
    step(); eret_m = 1'b0;
    at_neg();
    check("hold1", obs[1], {32'h0, 1'b1, 2'b00, 32'h4180, 1'b0, 1'b1});
    check_all("hold1");
    step(); intreq = 1'b0;
    at_neg();
    check("hold2", obs[1], {32'h0, 1'b1, 2'b00, 32'h4180, 1'b0, 1'b1});
    check_all("hold2");
    step();
    at_neg();
    check("hold_exit", {67'h0, f3, b3}, 69'h0);
    check_all("hold_exit");
    for (int k = 0; k < 6; k++) begin step(); at_neg(); check_all("coll_drain"); end

    // Reset mid-HOLD (FLUSH_CYCLES=5)
    step(); bd_m = 1'b0; exc_m = '0; intreq = 1'b1;
    step(); intreq = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("rst_mid_hold", obs[2], {32'h0, 1'b0, 2'b00, 32'h4180, 1'b0, 1'b0});
    check_all("rst_mid_hold");
    step(); rst = 1'b1;
    at_neg();
    check("rst_release", obs[2], {32'h0, 1'b0, 2'b00, 32'h4180, 1'b0, 1'b0});
    check_all("rst_release");

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      step();
      hwint   = 6'($urandom);
      m_valid = ($urandom_range(0, 3) != 0);
      exc_m   = 5'($urandom);
      bd_m    = 1'($urandom);
      eret_m  = ($urandom_range(0, 5) == 0);
      intreq  = ($urandom_range(0, 7) == 0);
      epc_i   = $urandom;
      rst     = ($urandom_range(0, 63) != 0);
      at_neg();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
